// File: rtl/stream_arbiter.sv
// Packet-level round-robin arbiter merging four AXI-Stream sources into one registered output
// slice, with a mid-packet stall watchdog that forces release of a hung source.
module stream_arbiter #(
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned IDLE_TIMEOUT = 255,
    parameter int unsigned TO_CNT_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_s_axis_tdata [4],
    input  logic [3:0]        i_s_axis_tvalid,
    input  logic [3:0]        i_s_axis_tlast,
    output logic [3:0]        o_s_axis_tready,
    output logic [DATA_W-1:0] o_m_axis_tdata,
    output logic              o_m_axis_tvalid,
    output logic              o_m_axis_tlast,
    input  logic              i_m_axis_tready,
    output logic [3:0]        o_grant,
    output logic              o_timeout
);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    localparam logic [TO_CNT_W-1:0] LP_TIMEOUT = TO_CNT_W'(IDLE_TIMEOUT);
    localparam bit                  LP_WD_EN   = (IDLE_TIMEOUT != 0);

    state_e              r_state,   w_state_d;
    logic [1:0]          r_owner,   w_owner_d;
    logic [1:0]          r_rr_ptr,  w_rr_ptr_d;
    logic [3:0]          r_grant,   w_grant_d;
    logic [TO_CNT_W-1:0] r_wd,      w_wd_d;
    logic                r_timeout, w_timeout_d;

    logic [DATA_W-1:0]   r_m_data,  w_m_data_d;
    logic                r_m_valid, w_m_valid_d;
    logic                r_m_last,  w_m_last_d;

    logic                w_out_free;
    logic                w_src_valid;
    logic                w_src_last;
    logic                w_accept;
    logic                w_req_found;
    logic [1:0]          w_req_idx;
    logic [1:0]          w_scan_idx;

    // Output slice can take a beat when empty or when its current beat leaves this cycle.
    assign w_out_free  = !r_m_valid || i_m_axis_tready;
    assign w_src_valid = i_s_axis_tvalid[r_owner];
    assign w_src_last  = i_s_axis_tlast[r_owner];
    assign w_accept    = (r_state == StLocked) && w_src_valid && w_out_free;

    always_comb begin
        o_s_axis_tready = '0;
        if (r_state == StLocked) begin
            o_s_axis_tready[r_owner] = w_out_free;
        end
    end

    // Rotating-priority scan starting at r_rr_ptr.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = r_rr_ptr;
        w_scan_idx  = r_rr_ptr;
        for (int i = 0; i < 4; i++) begin
            w_scan_idx = r_rr_ptr + 2'(i);
            if (!w_req_found && i_s_axis_tvalid[w_scan_idx]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_owner_d   = r_owner;
        w_rr_ptr_d  = r_rr_ptr;
        w_grant_d   = r_grant;
        w_wd_d      = r_wd;
        w_timeout_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req_found) begin
                    w_state_d  = StLocked;
                    w_owner_d  = w_req_idx;
                    w_grant_d  = 4'b0001 << w_req_idx;
                    w_rr_ptr_d = w_req_idx + 2'd1;
                    w_wd_d     = '0;
                end
            end
            StLocked: begin
                if (w_accept) begin
                    w_wd_d = '0;
                    if (w_src_last) begin
                        w_state_d = StIdle;
                        w_grant_d = '0;
                    end
                end else if (LP_WD_EN && !w_src_valid) begin
                    // Only source starvation counts; downstream stalls leave the counter alone.
                    w_wd_d = r_wd + TO_CNT_W'(1);
                    if (w_wd_d == LP_TIMEOUT) begin
                        w_state_d   = StIdle;
                        w_grant_d   = '0;
                        w_wd_d      = '0;
                        w_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    always_comb begin
        w_m_valid_d = r_m_valid;
        w_m_data_d  = r_m_data;
        w_m_last_d  = r_m_last;
        if (w_accept) begin
            w_m_valid_d = 1'b1;
            w_m_data_d  = i_s_axis_tdata[r_owner];
            w_m_last_d  = w_src_last;
        end else if (i_m_axis_tready) begin
            w_m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_wd      <= '0;
            r_timeout <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_owner   <= w_owner_d;
            r_rr_ptr  <= w_rr_ptr_d;
            r_grant   <= w_grant_d;
            r_wd      <= w_wd_d;
            r_timeout <= w_timeout_d;
            r_m_valid <= w_m_valid_d;
            r_m_data  <= w_m_data_d;
            r_m_last  <= w_m_last_d;
        end
    end

    assign o_m_axis_tdata  = r_m_data;
    assign o_m_axis_tvalid = r_m_valid;
    assign o_m_axis_tlast  = r_m_last;
    assign o_grant         = r_grant;
    assign o_timeout       = r_timeout;

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges up to four AXI-Stream packet sources into the single input stream of the packet router.
- Example sources: UART command decoder, enemy AI generator, replay/test-pattern source, spare.
- Holds ownership from a packet's first beat until its tlast beat is accepted, so packets never interleave.
- Drives a registered output slice and includes a stall watchdog so a hung source cannot lock the router forever.

Parameters:
- DATA_W, 64, stream data width; must match the router input width.
- IDLE_TIMEOUT, 255, consecutive stalled cycles allowed mid-packet before a forced release; 0 disables the watchdog.
- TO_CNT_W, 8, width of the watchdog counter; must satisfy 2^TO_CNT_W-1 >= IDLE_TIMEOUT.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_s_axis_tdata[k], k=0..3  in  DATA_W each  source k data; byte [7:0] holds the packet type.
- i_s_axis_tvalid[k]  in  1 each  source k beat valid.
- i_s_axis_tlast[k]  in  1 each  source k last beat of packet.
- o_s_axis_tready[k]  out  1 each  source k beat accepted.
- o_m_axis_tdata  out  DATA_W  merged stream data, to the router.
- o_m_axis_tvalid  out  1  merged stream valid.
- o_m_axis_tlast  out  1  merged stream last.
- i_m_axis_tready  in  1  router ready.
- o_grant  out  4  one-hot current owner; 0 when IDLE.
- o_timeout  out  1  one-cycle pulse on a forced release.

Behaviour:
- Reset values:
  - all o_s_axis_tready = 0
  - o_m_axis_tvalid = 0, o_m_axis_tdata = 0, o_m_axis_tlast = 0
  - o_grant = 0, o_timeout = 0
  - state = IDLE, rr_ptr = 0, watchdog = 0
- Reset mid-packet discards the output-register contents and any partial ownership. No partial beat is emitted after reset release.
- State IDLE:
  - Each cycle, scan tvalid in order rr_ptr, rr_ptr+1, ... (mod 4).
  - The first asserted source k wins: next state is LOCKED(k), o_grant = onehot(k) from the next cycle, and rr_ptr <= (k+1) mod 4.
  - With no requests, stay in IDLE and leave rr_ptr unchanged.
  - No tready is asserted while in IDLE, so the first beat is accepted no earlier than one cycle after the request.
- State LOCKED(k):
  - o_s_axis_tready[k] = !o_m_axis_tvalid || i_m_axis_tready. This is combinational from registered state and i_m_axis_tready only, never from tvalid.
  - All other tready are 0.
  - On an input beat accepted (tvalid[k] && tready[k]): load data and last into the output register; o_m_axis_tvalid = 1 next cycle.
  - On an output beat taken with no new load: clear o_m_axis_tvalid.
  - Simultaneous take and load: the register is replaced, valid stays 1.
  - Result: full throughput within a packet, 1-cycle input-to-output latency.
  - When the accepted input beat has tlast = 1, next state is IDLE. The output register may still hold that beat; IDLE arbitration proceeds regardless and the new owner's first beat waits on the register's readiness.
  - Single-beat packets (tlast on the first beat) are legal: LOCKED lasts until that one beat is accepted.
- Watchdog (IDLE_TIMEOUT != 0):
  - Clears on entry to LOCKED and on every accepted beat.
  - Increments each LOCKED cycle with tvalid[k] = 0.
  - A downstream stall (tvalid = 1, tready = 0) does not count.
  - When the counter reaches IDLE_TIMEOUT: force state to IDLE and pulse o_timeout for 1 cycle. The beats already forwarded stand; no tlast is fabricated.
- Simultaneous requests: exactly one grant per arbitration cycle; with 4 continuous requesters, grants rotate 0,1,2,3,0...
- o_grant is registered and stays stable for the whole LOCKED period.

Test Plan:
- Reset: hold i_rst=1 with all sources valid -> all tready 0, o_m_axis_tvalid 0, o_grant 0; after release, first grant is to source 0 (rr_ptr=0).
- Single source: src1 sends 3 beats with tdata low byte 0x01, tready held 1 -> o_m beats appear one cycle after each accept, tlast on the 3rd, o_grant=0010 throughout, then IDLE.
- Fairness: all four sources send continuous 2-beat packets -> grant order 0,1,2,3,0,1; no beat of one packet is interleaved with another.
- Backpressure: router holds tready=0 for 5 cycles mid-packet -> o_m data/last stable, source tready 0, watchdog does not fire, no beat lost or duplicated.
- Timeout: IDLE_TIMEOUT=4; src2 sends 1 beat without tlast, then drops tvalid -> o_timeout pulses exactly 4 cycles after the last accept, o_grant returns to 0, and waiting src3 is granted next.
- Reset mid-packet: assert i_rst during beat 2 of 4 -> outputs clear asynchronously; after release no stale beat is presented.
